// File: rtl/divider_pkg.sv
// Shared constants and types for the fixed-point divider family.
package divider_pkg;

  localparam int unsigned ARG_BIT_WIDTH = 32;
  localparam int unsigned PRECISION     = 64;
  localparam int unsigned QW            = ARG_BIT_WIDTH + PRECISION;
  localparam int unsigned ACCW          = 2 * ARG_BIT_WIDTH + PRECISION;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ROUND,
    DONE
  } rm_state_t;

endpackage

// File: rtl/fxp_round_sat.sv
// Fixed-point round-half-up, drop fraction bits and saturate to OUT_W bits.
module fxp_round_sat #(
  parameter int unsigned IN_W  = 128,
  parameter int unsigned FRAC  = 64,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  acc,
  output logic [OUT_W-1:0] a,
  output logic             ovf
);

  localparam logic [IN_W:0] HALF = (IN_W + 1)'(1) << (FRAC - 1);

  // One extra bit on the sum so the half-LSB add can never wrap.
  logic [IN_W:0]      sum;
  logic [IN_W-FRAC:0] r;

  always_comb begin
    sum = {1'b0, acc} + HALF;
    r   = sum[IN_W:FRAC];
    ovf = |r[IN_W-FRAC:OUT_W];
    a   = ovf ? '1 : r[OUT_W-1:0];
  end

endmodule

// File: rtl/quotient_remultiplier.sv
// Rebuilds dividend A' = round(Q*B / 2^PRECISION) with a one-bit-per-cycle shift-add multiplier.
module quotient_remultiplier
  import divider_pkg::*;
#(
  parameter int unsigned ARG_BIT_WIDTH = divider_pkg::ARG_BIT_WIDTH,
  parameter int unsigned PRECISION     = divider_pkg::PRECISION
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [ARG_BIT_WIDTH+PRECISION-1:0] q_in,
  input  logic [ARG_BIT_WIDTH-1:0]           b_in,
  input  logic                               dz_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ARG_BIT_WIDTH-1:0]           a_out,
  output logic                               ovf,
  output logic                               dz_out
);

  localparam int unsigned ACC_W = 2 * ARG_BIT_WIDTH + PRECISION;
  localparam int unsigned CNT_W = (ARG_BIT_WIDTH > 1) ? $clog2(ARG_BIT_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ARG_BIT_WIDTH - 1);

  rm_state_t state, state_nxt;

  logic [1:0]               rst_sync;
  logic                     rst_i_n;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         q_sh;
  logic [ARG_BIT_WIDTH-1:0] b_sh;
  logic [CNT_W-1:0]         cnt;
  logic                     dz_q;
  logic                     fast_q;
  logic                     fast_in;
  logic [ARG_BIT_WIDTH-1:0] rnd_a;
  logic                     rnd_ovf;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i_n = rst_sync[1];

  assign fast_in   = dz_in || (b_in == '0);
  assign in_ready  = (state == IDLE) && rst_i_n;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = fast_in ? ROUND : MUL;
      MUL:     if (cnt == CNT_LAST) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      acc    <= '0;
      q_sh   <= '0;
      b_sh   <= '0;
      cnt    <= '0;
      dz_q   <= 1'b0;
      fast_q <= 1'b0;
      a_out  <= '0;
      ovf    <= 1'b0;
      dz_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            q_sh   <= ACC_W'(q_in);
            b_sh   <= b_in;
            dz_q   <= dz_in;
            fast_q <= fast_in;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          if (b_sh[0]) acc <= acc + q_sh;
          q_sh <= q_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CNT_W'(1);
        end
        ROUND: begin
          a_out  <= fast_q ? '0 : rnd_a;
          ovf    <= fast_q ? 1'b0 : rnd_ovf;
          dz_out <= dz_q;
        end
        default: ;
      endcase
    end
  end

  fxp_round_sat #(
    .IN_W  (ACC_W),
    .FRAC  (PRECISION),
    .OUT_W (ARG_BIT_WIDTH)
  ) u_round_sat (
    .acc (acc),
    .a   (rnd_a),
    .ovf (rnd_ovf)
  );

endmodule

// File: tb/tb_quotient_remultiplier.sv
// Directed self-checking bench for quotient_remultiplier.
module tb_quotient_remultiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] q_in;
  logic [31:0] b_in;
  logic        dz_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a_out;
  logic        ovf;
  logic        dz_out;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  quotient_remultiplier #(
    .ARG_BIT_WIDTH (32),
    .PRECISION     (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_in      (q_in),
    .b_in      (b_in),
    .dz_in     (dz_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .ovf       (ovf),
    .dz_out    (dz_out)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check({tag, ".in_ready"}, 128'(in_ready), 128'(1));
  endtask

  // Accept one transaction, count edges (accept edge = 1) until out_valid, check and drain.
  task automatic run(input string tag, input logic [95:0] q, input logic [31:0] b, input logic dz,
                     input logic [31:0] ea, input logic eo, input logic ed, input int elat);
    int lat;
    q_in = q; b_in = b; dz_in = dz; in_valid = 1'b1;
    wait_ready(tag);
    @(posedge clk); #1;
    in_valid = 1'b0;
    q_in = '1; b_in = '1; dz_in = ~dz;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, ".latency"}, 128'(lat), 128'(elat));
    check({tag, ".a_out"}, 128'(a_out), 128'(ea));
    check({tag, ".ovf"}, 128'(ovf), 128'(eo));
    check({tag, ".dz_out"}, 128'(dz_out), 128'(ed));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drained"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q_in = '0; b_in = '0; dz_in = 1'b0;
    #23;
    check("rst.out_valid", 128'(out_valid), 128'(0));
    check("rst.a_out", 128'(a_out), 128'(0));
    check("rst.ovf", 128'(ovf), 128'(0));
    check("rst.dz_out", 128'(dz_out), 128'(0));
    check("rst.in_ready_low", 128'(in_ready), 128'(0));
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready_high", 128'(in_ready), 128'(1));

    run("mul3x7",  {32'd3, 64'd0},            32'd7,          1'b0, 32'd21,         1'b0, 1'b0, 34);
    run("half_up", 96'h8000_0000_0000_0000,   32'd3,          1'b0, 32'd2,          1'b0, 1'b0, 34);
    run("quarter", 96'h4000_0000_0000_0000,   32'd1,          1'b0, 32'd0,          1'b0, 1'b0, 34);
    run("sat",     {32'hFFFF_FFFF, 64'd0},    32'd2,          1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0, 34);
    run("max_nosat", {32'hFFFF_FFFF, 64'd0},  32'd1,          1'b0, 32'hFFFF_FFFF,  1'b0, 1'b0, 34);
    run("b_max",   {32'd1, 64'd0},            32'hFFFF_FFFF,  1'b0, 32'hFFFF_FFFF,  1'b0, 1'b0, 34);
    run("frac",    {32'd10, 64'h8000_0000_0000_0000}, 32'd2,  1'b0, 32'd21,         1'b0, 1'b0, 34);
    run("dz",      {32'd5, 64'd0},            32'd3,          1'b1, 32'd0,          1'b0, 1'b1, 2);
    run("b_zero",  {32'd9, 64'd0},            32'd0,          1'b0, 32'd0,          1'b0, 1'b0, 2);

    // Backpressure: result held, in_ready low, in_valid pulses ignored.
    q_in = {32'd6, 64'd0}; b_in = 32'd4; dz_in = 1'b0; in_valid = 1'b1;
    wait_ready("hold");
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      q_in = {32'd100 + 32'(i), 64'd0}; b_in = 32'd1;
      @(posedge clk); #1;
      check("hold.out_valid", 128'(out_valid), 128'(1));
      check("hold.a_out", 128'(a_out), 128'(24));
      check("hold.in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold.drained", 128'(out_valid), 128'(0));
    check("hold.idle_ready", 128'(in_ready), 128'(1));
    repeat (3) @(posedge clk);
    #1;
    check("hold.no_ghost", 128'(out_valid), 128'(0));

    // Abort in the middle of the multiply.
    q_in = {32'd7, 64'd0}; b_in = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort.pre_a_out", 128'(a_out), 128'(24));
    rst_n = 1'b0;
    #1;
    check("abort.out_valid", 128'(out_valid), 128'(0));
    check("abort.a_out", 128'(a_out), 128'(0));
    check("abort.in_ready", 128'(in_ready), 128'(0));
    #20;
    rst_n = 1'b1;
    run("after_abort", {32'd2, 64'd0}, 32'd5, 1'b0, 32'd10, 1'b0, 1'b0, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
